// File: rtl/adc_capture_fifo_pkg.sv
// adc_capture_fifo_pkg: shared capture FSM state encoding and default sizes
package adc_capture_fifo_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;
  localparam int ADC_W_DEF = 12;
  localparam int DEPTH_LOG2_DEF = 10;
  localparam int DIV_W_DEF = 16;
endpackage

// File: rtl/adc_capture_fifo_if.sv
// adc_capture_fifo_if: ADC pins, capture control, MCU read strobe and FIFO status
interface adc_capture_fifo_if
  import adc_capture_fifo_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DIV_W = DIV_W_DEF
);
  logic [ADC_W-1:0] adc_data;
  logic start;
  logic [DIV_W-1:0] div;
  logic [DEPTH_LOG2:0] count;
  logic sel;
  logic nrd;
  logic [15:0] data_out;
  logic busy;
  logic done;
  logic [DEPTH_LOG2:0] level;
  logic overrun;
  logic underflow;
  modport master (
    output adc_data, start, div, count, sel, nrd,
    input data_out, busy, done, level, overrun, underflow
  );
  modport slave (
    input adc_data, start, div, count, sel, nrd,
    output data_out, busy, done, level, overrun, underflow
  );
endinterface

// File: rtl/adc_capture_fifo_sample_ram.sv
// sample_ram: simple dual-port block RAM, one write port, one registered read port
module sample_ram #(
  parameter int W = 12,
  parameter int AW = 10
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [W-1:0] wdata,
  input logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/adc_capture_fifo.sv
// adc_capture_fifo: decimated ADC capture into a FIFO drained by synchronised MCU reads
// ports: clk, rst (sync, active-high); bus carries ADC data, START/DIV/COUNT, SEL/NRD, DATA_OUT and status
module adc_capture_fifo
  import adc_capture_fifo_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input logic clk,
  input logic rst,
  adc_capture_fifo_if.slave bus
);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  state_t state;
  logic [2:0] sync;
  logic armed;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] divcnt;
  logic [DEPTH_LOG2:0] remain;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [ADC_W-1:0] rdata;
  logic ne_q;
  logic fall, rise, pop, pop_ok, push, push_ok, start_ok;
  // sync[1:0] is the two-flop synchroniser, sync[2] the previous synced value for edge detection
  assign fall = sync[2] & ~sync[1];
  assign rise = ~sync[2] & sync[1];
  assign pop = rise & armed;
  assign pop_ok = pop & (bus.level != '0);
  assign push = (state == CAPTURE) && (divcnt == '0);
  // a full FIFO still takes the sample when a pop frees a slot on the same edge
  assign push_ok = push & ((bus.level != FULL) | pop_ok);
  assign start_ok = bus.start && (state != CAPTURE);
  sample_ram #(.W(ADC_W), .AW(DEPTH_LOG2)) u_ram (
    .clk(clk),
    .we(push_ok),
    .waddr(wr_ptr),
    .wdata(bus.adc_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sync <= 3'b111;
      armed <= 1'b0;
      div_l <= '0;
      divcnt <= '0;
      remain <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ne_q <= 1'b0;
      bus.level <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.overrun <= 1'b0;
      bus.underflow <= 1'b0;
      bus.data_out <= 16'h0000;
    end else begin
      sync <= {sync[1:0], bus.nrd};
      armed <= fall ? bus.sel : rise ? 1'b0 : armed;
      // ne_q travels with the registered RAM read so the head register sees matching emptiness
      ne_q <= bus.level != '0;
      bus.data_out <= ne_q ? 16'(rdata) : 16'h0000;
      if (start_ok) begin
        state <= (bus.count == '0) ? DONE : CAPTURE;
        bus.busy <= bus.count != '0;
        bus.done <= bus.count == '0;
        div_l <= bus.div;
        remain <= bus.count;
        divcnt <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        bus.level <= '0;
        bus.overrun <= 1'b0;
        bus.underflow <= 1'b0;
      end else begin
        if (pop && !pop_ok) bus.underflow <= 1'b1;
        if (push && !push_ok) bus.overrun <= 1'b1;
        if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        bus.level <= bus.level + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);
        if (state == CAPTURE) begin
          divcnt <= (divcnt == div_l) ? '0 : divcnt + 1'b1;
          if (push) begin
            remain <= remain - 1'b1;
            if (remain == (DEPTH_LOG2+1)'(1)) begin
              state <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_fifo.sv
// tb_adc_capture_fifo: randomized capture/read stimulus checked against a queue-based model
module tb_adc_capture_fifo;
  localparam int ADC_W = 12;
  localparam int DL2 = 4;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  adc_capture_fifo_if #(.ADC_W(ADC_W), .DEPTH_LOG2(DL2), .DIV_W(16)) bus ();
  adc_capture_fifo #(.ADC_W(ADC_W), .DEPTH_LOG2(DL2), .DIV_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  int cyc = 0;
  int adc_off = 0;
  bit rnd = 1'b1;
  always @(negedge clk) bus.adc_data = rnd ? ADC_W'($urandom) : ADC_W'(adc_off + cyc + 1);
  logic [ADC_W-1:0] q[$];
  logic [2:0] hist;
  logic armed, capt, m_busy, m_done, m_ov, m_uf, m_ok, fall, rise, popr;
  int nxt, left, dv, age, exp_h, h;
  initial begin
    m_ok = 1'b0;
    exp_h = 0;
    age = 0;
  end
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      {m_busy, m_done, m_ov, m_uf, armed, capt} = '0;
      hist = 3'b111;
      m_ok = 1'b1;
    end else begin
      fall = hist[2] & ~hist[1];
      rise = ~hist[2] & hist[1];
      popr = rise & armed;
      if (fall) armed = bus.sel;
      else if (rise) armed = 1'b0;
      hist = {hist[1:0], bus.nrd};
      if (bus.start && !capt) begin
        q.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;
        left = int'(bus.count);
        dv = int'(bus.div);
        nxt = cyc + 1;
        capt = left != 0;
        m_busy = capt;
        m_done = !capt;
      end else begin
        if (popr) begin
          if (q.size() == 0) m_uf = 1'b1;
          else void'(q.pop_front());
        end
        if (capt && cyc == nxt) begin
          if (q.size() < DEPTH) q.push_back(bus.adc_data);
          else m_ov = 1'b1;
          left--;
          nxt += dv + 1;
          if (left == 0) begin
            capt = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
    h = (q.size() != 0) ? int'(q[0]) : 0;
    if (h != exp_h) begin
      exp_h = h;
      age = 0;
    end else if (age < 2) age++;
  end
  always @(negedge clk) begin
    if (m_ok) begin
      chk("level", int'(bus.level), q.size());
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      chk("overrun", int'(bus.overrun), int'(m_ov));
      chk("underflow", int'(bus.underflow), int'(m_uf));
      if (age >= 2) chk("data_out", int'(bus.data_out), exp_h);
    end
  end
  task automatic do_start(input int d, input int c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.div = 16'(d);
    bus.count = 5'(c);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic rd(input bit s, input int lo, input int hi);
    @(negedge clk);
    bus.nrd = 1'b0;
    bus.sel = s;
    repeat (lo) @(negedge clk);
    bus.nrd = 1'b1;
    repeat (hi) @(negedge clk);
    bus.sel = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int n = 0;
    while (!bus.done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", int'(bus.done), 1);
  endtask
  task automatic drain();
    int n = 0;
    while (bus.level != '0 && n < 40) begin
      rd(1'b1, 5, 6);
      n++;
    end
    chk("drain", int'(bus.level), 0);
  endtask
  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) rd(1'b1, $urandom_range(4, 7), $urandom_range(4, 7));
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.div = '0;
    bus.count = '0;
    bus.sel = 1'b0;
    bus.nrd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_dout", int'(bus.data_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ovr", int'(bus.overrun), 0);
    chk("rst_udf", int'(bus.underflow), 0);
    @(negedge clk);
    adc_off = 100 - (cyc + 3);
    rnd = 1'b0;
    do_start(3, 5);
    chk("t1_busy", int'(bus.busy), 1);
    chk("t1_lvl0", int'(bus.level), 0);
    @(negedge clk);
    chk("t1_lvl1", int'(bus.level), 1);
    wait_done(100);
    chk("t1_level", int'(bus.level), 5);
    chk("t1_busy_end", int'(bus.busy), 0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_head", int'(bus.data_out), 100 + 4 * i);
      rd(1'b1, 5, 6);
    end
    chk("t1_empty_dout", int'(bus.data_out), 0);
    chk("t1_empty_lvl", int'(bus.level), 0);
    chk("t1_udf0", int'(bus.underflow), 0);
    rd(1'b1, 5, 6);
    chk("t1_udf1", int'(bus.underflow), 1);
    rnd = 1'b1;
    do_start(0, 20);
    chk("t2_udf_clr", int'(bus.underflow), 0);
    wait_done(100);
    chk("t2_level", int'(bus.level), 16);
    chk("t2_ovr", int'(bus.overrun), 1);
    rd(1'b0, 5, 6);
    chk("t2_nosel", int'(bus.level), 16);
    rd(1'b1, 5, 6);
    chk("t2_pop", int'(bus.level), 15);
    chk("t2_ovr_sticky", int'(bus.overrun), 1);
    drain();
    fork
      begin
        do_start(7, 40);
        wait_done(600);
      end
      rand_reads(30);
    join
    drain();
    repeat (6) begin
      fork
        begin
          do_start($urandom_range(0, 4), $urandom_range(0, 24));
          wait_done(200);
        end
        rand_reads($urandom_range(3, 12));
      join
      drain();
    end
    do_start(2, 30);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r1_level", int'(bus.level), 0);
    chk("r1_busy", int'(bus.busy), 0);
    chk("r1_done", int'(bus.done), 0);
    chk("r1_dout", int'(bus.data_out), 0);
    repeat (5) @(negedge clk);
    chk("r1_abort", int'(bus.level), 0);
    do_start(0, 3);
    wait_done(20);
    @(negedge clk);
    bus.nrd = 1'b0;
    bus.sel = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("r2_level", int'(bus.level), 0);
    repeat (6) @(negedge clk);
    bus.nrd = 1'b1;
    repeat (6) @(negedge clk);
    chk("r2_udf", int'(bus.underflow), 0);
    chk("r2_level_end", int'(bus.level), 0);
    chk("r2_dout", int'(bus.data_out), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
